count_date: RTL

- Day/month calendar counter for the century clock.
- Sits between the hour/day carry and the year counter.
- Consumes the year counter's leap_year flag and produces its en_yr increment pulse on the Dec 31 -> Jan 1 rollover.
- Holds day and month as BCD digit pairs and supports manual up/down adjust of either field.

---
 rtl/date_pkg.sv | 76 +++++++
 rtl/count_date_month_len.sv | 35 +++
 rtl/count_date.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/date_pkg.sv
// -----------------------------------------------------------------------------
// date_pkg
// Shared types, constants and BCD helpers for the day/month calendar counter.
//   bcd_t        : one BCD digit (4 bits, values 0..9)
//   bcd2_t       : BCD digit pair {ten, unit}; packed so that an ordinary
//                  unsigned compare of two legal pairs orders them numerically
//   JAN..DEC     : month numbers as BCD pairs
//   MAX_DAY_*    : month lengths as BCD pairs
//   WEEKDAY_RST  : weekday at reset (Saturday, matching 01/01/2000)
// -----------------------------------------------------------------------------
package date_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t ten;
    bcd_t unit;
  } bcd2_t;

  localparam bcd2_t JAN = 8'h01;
  localparam bcd2_t FEB = 8'h02;
  localparam bcd2_t MAR = 8'h03;
  localparam bcd2_t APR = 8'h04;
  localparam bcd2_t MAY = 8'h05;
  localparam bcd2_t JUN = 8'h06;
  localparam bcd2_t JUL = 8'h07;
  localparam bcd2_t AUG = 8'h08;
  localparam bcd2_t SEP = 8'h09;
  localparam bcd2_t OCT = 8'h10;
  localparam bcd2_t NOV = 8'h11;
  localparam bcd2_t DEC = 8'h12;

  localparam bcd2_t MAX_DAY_31 = 8'h31;
  localparam bcd2_t MAX_DAY_30 = 8'h30;
  localparam bcd2_t FEB_LEAP   = 8'h29;
  localparam bcd2_t FEB_NORM   = 8'h28;

  localparam bcd2_t DAY_ONE    = 8'h01;

  localparam logic [2:0] WEEKDAY_RST = 3'd6;

  // BCD pair increment; unit 9 carries into the tens digit.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    if (v.unit == 4'd9) begin
      r.ten  = v.ten + 4'd1;
      r.unit = 4'd0;
    end else begin
      r.ten  = v.ten;
      r.unit = v.unit + 4'd1;
    end
    return r;
  endfunction

  // BCD pair decrement; unit 0 borrows from the tens digit and becomes 9.
  function automatic bcd2_t bcd2_dec(input bcd2_t v);
    bcd2_t r;
    if (v.unit == 4'd0) begin
      r.ten  = v.ten - 4'd1;
      r.unit = 4'd9;
    end else begin
      r.ten  = v.ten;
      r.unit = v.unit - 4'd1;
    end
    return r;
  endfunction

  // Binary 0..99 to BCD pair; used only on elaboration-time constants.
  function automatic bcd2_t bin_to_bcd2(input int unsigned v);
    bcd2_t r;
    r.ten  = 4'(v / 32'd10);
    r.unit = 4'(v % 32'd10);
    return r;
  endfunction

endpackage

// File: rtl/count_date_month_len.sv
// -----------------------------------------------------------------------------
// month_len
// Combinational month-length lookup in BCD.
// Ports:
//   i_month     : BCD month 01..12
//   i_leap_year : 1 when the current year is leap (February has 29 days)
//   o_max_day   : BCD number of days in i_month
// An out-of-range month code falls back to 31 days.
// -----------------------------------------------------------------------------
module month_len
  import date_pkg::*;
(
  input  bcd2_t i_month,
  input  logic  i_leap_year,
  output bcd2_t o_max_day
);

  // Month-to-length table; February depends on the leap flag.
  always_comb begin
    o_max_day = MAX_DAY_31;
    case (i_month)
      FEB: begin
        if (i_leap_year) begin
          o_max_day = FEB_LEAP;
        end else begin
          o_max_day = FEB_NORM;
        end
      end
      APR, JUN, SEP, NOV: o_max_day = MAX_DAY_30;
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: o_max_day = MAX_DAY_31;
      default: o_max_day = MAX_DAY_31;
    endcase
  end

endmodule

// File: rtl/count_date.sv
// -----------------------------------------------------------------------------
// count_date
// Day/month calendar counter of the century clock. Advances on the midnight
// carry, rolls the year over on Dec 31 -> Jan 1 and supports manual up/down
// adjustment of either the day or the month field.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   en_day      : one-cycle day-advance strobe
//   leap_year   : level, current year is leap
//   up, down    : manual adjust requests (one step per cycle)
//   sel_month   : adjust target, 0 = day, 1 = month
//   day_unit/day_ten, month_unit/month_ten : BCD date digits (registered)
//   en_yr       : registered one-cycle pulse on the 31/12 -> 01/01 rollover
//   weekday     : (only with WEEKDAY_EN) 0 = Sunday .. 6 = Saturday
// Build option: define WEEKDAY_EN to add the weekday counter and port.
// Per-cycle priority: en_day > manual adjust > clamp to month length > hold.
// -----------------------------------------------------------------------------
module count_date
  import date_pkg::*;
#(
  parameter int DIGIT_W   = 4,
  parameter int RST_DAY   = 1,
  parameter int RST_MONTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_day,
  input  logic               leap_year,
  input  logic               up,
  input  logic               down,
  input  logic               sel_month,
  output logic [DIGIT_W-1:0] day_unit,
  output logic [DIGIT_W-1:0] day_ten,
  output logic [DIGIT_W-1:0] month_unit,
  output logic [DIGIT_W-1:0] month_ten,
  output logic               en_yr
`ifdef WEEKDAY_EN
  ,
  output logic [2:0]         weekday
`endif
);

  localparam bcd2_t RST_DAY_BCD   = bin_to_bcd2(int'(RST_DAY));
  localparam bcd2_t RST_MONTH_BCD = bin_to_bcd2(int'(RST_MONTH));

  bcd2_t r_day;
  bcd2_t r_month;
  logic  r_en_yr;

  bcd2_t w_day_nxt;
  bcd2_t w_month_nxt;
  logic  w_en_yr_nxt;

  bcd2_t w_cur_len;
  bcd2_t w_adj_month;
  bcd2_t w_adj_len;
  logic  w_adjust;

  // Exactly one of up/down requests a step; both high means hold.
  assign w_adjust = up ^ down;

  // Month a manual month adjust would move to, wrapping 12 <-> 01.
  always_comb begin
    w_adj_month = r_month;
    if (up) begin
      if (r_month == DEC) begin
        w_adj_month = JAN;
      end else begin
        w_adj_month = bcd2_inc(r_month);
      end
    end else begin
      if (r_month == JAN) begin
        w_adj_month = DEC;
      end else begin
        w_adj_month = bcd2_dec(r_month);
      end
    end
  end

  month_len u_len_cur (
    .i_month     (r_month),
    .i_leap_year (leap_year),
    .o_max_day   (w_cur_len)
  );

  // Length of the month being adjusted into, for same-edge day clamping.
  month_len u_len_adj (
    .i_month     (w_adj_month),
    .i_leap_year (leap_year),
    .o_max_day   (w_adj_len)
  );

  // Next-state date and year-carry computation.
  always_comb begin
    w_day_nxt   = r_day;
    w_month_nxt = r_month;
    w_en_yr_nxt = 1'b0;
    if (en_day) begin
      if (r_day < w_cur_len) begin
        w_day_nxt = bcd2_inc(r_day);
      end else begin
        w_day_nxt = DAY_ONE;
        if (r_month == DEC) begin
          w_month_nxt = JAN;
          w_en_yr_nxt = 1'b1;
        end else begin
          w_month_nxt = bcd2_inc(r_month);
        end
      end
    end else if (w_adjust) begin
      if (sel_month) begin
        w_month_nxt = w_adj_month;
        if (r_day > w_adj_len) begin
          w_day_nxt = w_adj_len;
        end else begin
          w_day_nxt = r_day;
        end
      end else if (up) begin
        // >= also wraps a day left above the length by a leap_year drop.
        if (r_day >= w_cur_len) begin
          w_day_nxt = DAY_ONE;
        end else begin
          w_day_nxt = bcd2_inc(r_day);
        end
      end else begin
        if (r_day == DAY_ONE) begin
          w_day_nxt = w_cur_len;
        end else begin
          w_day_nxt = bcd2_dec(r_day);
        end
      end
    end else if (r_day > w_cur_len) begin
      // leap_year fell while on 29/02.
      w_day_nxt = w_cur_len;
    end else begin
      w_day_nxt = r_day;
    end
  end

  // Date and year-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_day   <= RST_DAY_BCD;
      r_month <= RST_MONTH_BCD;
      r_en_yr <= 1'b0;
    end else begin
      r_day   <= w_day_nxt;
      r_month <= w_month_nxt;
      r_en_yr <= w_en_yr_nxt;
    end
  end

  assign day_unit   = DIGIT_W'(r_day.unit);
  assign day_ten    = DIGIT_W'(r_day.ten);
  assign month_unit = DIGIT_W'(r_month.unit);
  assign month_ten  = DIGIT_W'(r_month.ten);
  assign en_yr      = r_en_yr;

`ifdef WEEKDAY_EN
  logic [2:0] r_weekday;
  logic [2:0] w_weekday_nxt;

  // Weekday follows calendar days only; manual adjust leaves it alone.
  always_comb begin
    w_weekday_nxt = r_weekday;
    if (en_day) begin
      if (r_weekday == 3'd6) begin
        w_weekday_nxt = 3'd0;
      end else begin
        w_weekday_nxt = r_weekday + 3'd1;
      end
    end else begin
      w_weekday_nxt = r_weekday;
    end
  end

  // Weekday register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weekday <= WEEKDAY_RST;
    end else begin
      r_weekday <= w_weekday_nxt;
    end
  end

  assign weekday = r_weekday;
`endif

endmodule
